// File: rtl/dsp_mac_unit.sv
// Pipelined signed multiply-accumulate with optional pre-adder.
// Accumulates ACC_LEN products per frame and presents each frame sum on P with an overflow flag.
module dsp_mac_unit #(
   parameter int A_WIDTH  = 18,
   parameter int B_WIDTH  = 18,
   parameter int P_WIDTH  = 48,
   parameter int ACC_LEN  = 16,
   parameter int SATURATE = 1
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       IN_VALID,
   output logic                       IN_READY,
   input  logic signed [A_WIDTH-1:0]  A,
   input  logic signed [B_WIDTH-1:0]  B,
   input  logic signed [B_WIDTH-1:0]  D,
   input  logic                       PREADD_EN,
   input  logic                       PRE_SUB,
   input  logic                       ACC_SUB,
   output logic                       OUT_VALID,
   input  logic                       OUT_READY,
   output logic signed [P_WIDTH-1:0]  P,
   output logic                       OVERFLOW,
   output logic                       BUSY
);

   localparam int PRE_W  = B_WIDTH + 1;
   localparam int PROD_W = A_WIDTH + B_WIDTH + 1;
   localparam int SUM_W  = P_WIDTH + 1;
   localparam int CNT_W  = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);
   localparam logic signed [P_WIDTH-1:0] P_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
   localparam logic signed [P_WIDTH-1:0] P_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};

   logic en;
   logic accept;
   logic [CNT_W-1:0] count;

   logic                      s1_valid, s1_last, s1_first;
   logic signed [A_WIDTH-1:0] s1_a;
   logic signed [B_WIDTH-1:0] s1_b, s1_d;
   logic                      s1_pe, s1_ps, s1_as;

   logic                      s2_valid, s2_last, s2_first, s2_as;
   logic signed [PROD_W-1:0]  s2_prod;

   logic                      s3_valid, s3_last;
   logic signed [P_WIDTH-1:0] acc;
   logic                      acc_ovf;

   logic signed [PRE_W-1:0]   pre_c;
   logic signed [PROD_W-1:0]  prod_c;
   logic signed [P_WIDTH-1:0] base_c;
   logic signed [SUM_W-1:0]   sum_w;
   logic                      step_ovf;
   logic signed [P_WIDTH-1:0] sum_sel;

   // A stalled output freezes the entire pipeline, so nothing is ever dropped.
   assign en       = !(OUT_VALID && !OUT_READY);
   assign IN_READY = en;
   assign accept   = IN_VALID && en;
   assign BUSY     = (count != '0) || s1_valid || s2_valid || s3_valid;

   assign pre_c  = s1_pe ? (s1_ps ? PRE_W'(s1_d) - PRE_W'(s1_b)
                                  : PRE_W'(s1_d) + PRE_W'(s1_b))
                         : PRE_W'(s1_b);
   assign prod_c = PROD_W'(s1_a) * PROD_W'(pre_c);

   // One guard bit above the accumulator exposes signed overflow of each step.
   assign base_c   = s2_first ? '0 : acc;
   assign sum_w    = s2_as ? SUM_W'(base_c) - SUM_W'(s2_prod)
                           : SUM_W'(base_c) + SUM_W'(s2_prod);
   assign step_ovf = sum_w[SUM_W-1] != sum_w[SUM_W-2];
   assign sum_sel  = (SATURATE != 0 && step_ovf) ? (sum_w[SUM_W-1] ? P_MIN : P_MAX)
                                                 : sum_w[P_WIDTH-1:0];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count     <= '0;
         s1_valid  <= 1'b0;
         s1_last   <= 1'b0;
         s1_first  <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_d      <= '0;
         s1_pe     <= 1'b0;
         s1_ps     <= 1'b0;
         s1_as     <= 1'b0;
         s2_valid  <= 1'b0;
         s2_last   <= 1'b0;
         s2_first  <= 1'b0;
         s2_as     <= 1'b0;
         s2_prod   <= '0;
         s3_valid  <= 1'b0;
         s3_last   <= 1'b0;
         acc       <= '0;
         acc_ovf   <= 1'b0;
         OUT_VALID <= 1'b0;
         P         <= '0;
         OVERFLOW  <= 1'b0;
      end else if (en) begin
         if (accept)
            count <= (count == LAST_CNT) ? '0 : count + 1'b1;

         s1_valid <= accept;
         s1_last  <= accept && (count == LAST_CNT);
         s1_first <= accept && (count == '0);
         s1_a     <= A;
         s1_b     <= B;
         s1_d     <= D;
         s1_pe    <= PREADD_EN;
         s1_ps    <= PRE_SUB;
         s1_as    <= ACC_SUB;

         s2_valid <= s1_valid;
         s2_last  <= s1_last;
         s2_first <= s1_first;
         s2_as    <= s1_as;
         s2_prod  <= prod_c;

         s3_valid <= s2_valid;
         s3_last  <= s2_valid && s2_last;
         if (s2_valid) begin
            acc     <= sum_sel;
            acc_ovf <= (s2_first ? 1'b0 : acc_ovf) | step_ovf;
         end

         OUT_VALID <= s3_valid && s3_last;
         if (s3_valid && s3_last) begin
            P        <= acc;
            OVERFLOW <= acc_ovf;
         end
      end
   end

endmodule

// File: tb/tb_dsp_mac_unit.sv
// Directed bench for dsp_mac_unit: frame sums, latency, pre-adder, saturation/wrap,
// output back-pressure, mid-frame reset and sparse input.
module tb_dsp_mac_unit;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic signed [17:0] a, b, d;
   logic preadd_en, pre_sub, acc_sub;

   logic v4, rdy4, ov4, ordy4, of4, busy4;
   logic signed [47:0] p4;
   logic v2, rdy2, ov2, ordy2, of2, busy2;
   logic signed [47:0] p2;

   logic signed [7:0] a8, b8, d8;
   logic v8, ordy8;
   logic rdy_s, ov_s, of_s, busy_s, rdy_w, ov_w, of_w, busy_w;
   logic signed [19:0] p_s, p_w;

   int errors = 0;
   int checks = 0;

   int va  [4] = '{3, -4, 10, 1};
   int vb  [4] = '{-2, 6, 10, 9};
   int vd  [4] = '{7, 100, 0, 0};
   bit vpe [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
   bit vas [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

   dsp_mac_unit #(.ACC_LEN(4)) u4 (
      .CLK(clk), .RST(rst), .IN_VALID(v4), .IN_READY(rdy4),
      .A(a), .B(b), .D(d), .PREADD_EN(preadd_en), .PRE_SUB(pre_sub), .ACC_SUB(acc_sub),
      .OUT_VALID(ov4), .OUT_READY(ordy4), .P(p4), .OVERFLOW(of4), .BUSY(busy4));

   dsp_mac_unit #(.ACC_LEN(2)) u2 (
      .CLK(clk), .RST(rst), .IN_VALID(v2), .IN_READY(rdy2),
      .A(a), .B(b), .D(d), .PREADD_EN(preadd_en), .PRE_SUB(pre_sub), .ACC_SUB(acc_sub),
      .OUT_VALID(ov2), .OUT_READY(ordy2), .P(p2), .OVERFLOW(of2), .BUSY(busy2));

   dsp_mac_unit #(.A_WIDTH(8), .B_WIDTH(8), .P_WIDTH(20), .ACC_LEN(64), .SATURATE(1)) us (
      .CLK(clk), .RST(rst), .IN_VALID(v8), .IN_READY(rdy_s),
      .A(a8), .B(b8), .D(d8), .PREADD_EN(preadd_en), .PRE_SUB(pre_sub), .ACC_SUB(acc_sub),
      .OUT_VALID(ov_s), .OUT_READY(ordy8), .P(p_s), .OVERFLOW(of_s), .BUSY(busy_s));

   dsp_mac_unit #(.A_WIDTH(8), .B_WIDTH(8), .P_WIDTH(20), .ACC_LEN(64), .SATURATE(0)) uw (
      .CLK(clk), .RST(rst), .IN_VALID(v8), .IN_READY(rdy_w),
      .A(a8), .B(b8), .D(d8), .PREADD_EN(preadd_en), .PRE_SUB(pre_sub), .ACC_SUB(acc_sub),
      .OUT_VALID(ov_w), .OUT_READY(ordy8), .P(p_w), .OVERFLOW(of_w), .BUSY(busy_w));

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send4(input int sa, input int sb, input int sd,
                        input logic pe, input logic ps, input logic as);
      logic took;
      int n;
      a = 18'(sa); b = 18'(sb); d = 18'(sd);
      preadd_en = pe; pre_sub = ps; acc_sub = as;
      v4 = 1'b1;
      took = 1'b0;
      n = 0;
      while (!took && n < 50) begin
         took = rdy4;
         tick();
         n++;
      end
      chk("accept4", took, 1);
   endtask

   task automatic wait4();
      int n;
      n = 0;
      while (!ov4 && n < 100) begin
         tick();
         n++;
      end
      chk("out_valid4", ov4, 1);
   endtask

   initial begin
      rst = 1'b1;
      a = '0; b = '0; d = '0; preadd_en = 1'b0; pre_sub = 1'b0; acc_sub = 1'b0;
      a8 = '0; b8 = '0; d8 = '0;
      v4 = 1'b0; v2 = 1'b0; v8 = 1'b0;
      ordy4 = 1'b1; ordy2 = 1'b1; ordy8 = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      chk("rst_p", p4, 0);
      chk("rst_out_valid", ov4, 0);
      chk("rst_overflow", of4, 0);
      chk("rst_busy", busy4, 0);
      chk("rst_in_ready", rdy4, 1);

      // 4 x (2*3) with exact output latency
      repeat (4) send4(2, 3, 0, 1'b0, 1'b0, 1'b0);
      v4 = 1'b0;
      tick(); chk("lat_edge1", ov4, 0);
      tick(); chk("lat_edge2", ov4, 0);
      tick(); chk("lat_edge3", ov4, 1);
      chk("basic_p", p4, 24);
      chk("basic_ovf", of4, 0);
      tick(); chk("handshake_clear", ov4, 0);

      // 5*(10-4) - 5*(10-(-4)) = 30 - 70
      a = 18'(5); d = 18'(10); b = 18'(4);
      preadd_en = 1'b1; pre_sub = 1'b1; acc_sub = 1'b0;
      v2 = 1'b1;
      chk("len2_ready", rdy2, 1);
      tick();
      b = -18'sd4; acc_sub = 1'b1;
      tick();
      v2 = 1'b0; preadd_en = 1'b0; pre_sub = 1'b0; acc_sub = 1'b0;
      repeat (3) tick();
      chk("len2_valid", ov2, 1);
      chk("len2_p", p2, -40);
      chk("len2_ovf", of2, 0);
      tick();

      // 64 x 16384 = 2^20 overflows a 20-bit accumulator
      a8 = 8'sh80; b8 = 8'sh80; d8 = '0;
      v8 = 1'b1;
      chk("sat_ready", rdy_s, 1);
      repeat (64) tick();
      v8 = 1'b0;
      repeat (3) tick();
      chk("sat_valid", ov_s, 1);
      chk("sat_p", p_s, 524287);
      chk("sat_ovf", of_s, 1);
      chk("wrap_valid", ov_w, 1);
      chk("wrap_p", p_w, 0);
      chk("wrap_ovf", of_w, 1);
      tick();
      a8 = 8'sd1; b8 = 8'sd1;
      v8 = 1'b1;
      repeat (64) tick();
      v8 = 1'b0;
      repeat (3) tick();
      chk("sat2_valid", ov_s, 1);
      chk("sat2_p", p_s, 64);
      chk("sat2_ovf", of_s, 0);
      chk("wrap2_p", p_w, 64);
      chk("wrap2_ovf", of_w, 0);
      tick();

      // Back-pressure: frame1 = 4*5 held on P while frame2 (3*(1+2+3+4)) waits
      ordy4 = 1'b0;
      repeat (4) send4(1, 5, 0, 1'b0, 1'b0, 1'b0);
      send4(3, 1, 0, 1'b0, 1'b0, 1'b0);
      send4(3, 2, 0, 1'b0, 1'b0, 1'b0);
      send4(3, 3, 0, 1'b0, 1'b0, 1'b0);
      a = 18'(3); b = 18'(4); v4 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("stall_in_ready", rdy4, 0);
         chk("stall_valid", ov4, 1);
         chk("stall_p", p4, 20);
         tick();
      end
      ordy4 = 1'b1;
      send4(3, 4, 0, 1'b0, 1'b0, 1'b0);
      v4 = 1'b0;
      wait4();
      chk("after_stall_p", p4, 30);
      chk("after_stall_ovf", of4, 0);
      tick();

      // Reset mid-frame
      repeat (2) send4(7, 7, 0, 1'b0, 1'b0, 1'b0);
      v4 = 1'b0;
      chk("pre_rst_busy", busy4, 1);
      chk("pre_rst_p", p4, 30);
      rst = 1'b1;
      #1;
      chk("async_rst_p", p4, 0);
      chk("async_rst_valid", ov4, 0);
      chk("async_rst_ovf", of4, 0);
      chk("async_rst_busy", busy4, 0);
      #2;
      rst = 1'b0;
      tick();
      chk("post_rst_ready", rdy4, 1);
      repeat (4) send4(1, 1, 0, 1'b0, 1'b0, 1'b0);
      v4 = 1'b0;
      wait4();
      chk("post_rst_p", p4, 4);
      tick();

      // Mixed frame: 3*(7+(-2)) - 4*6 - 10*10 + 1*9 = -100, dense then sparse
      for (int i = 0; i < 4; i++)
         send4(va[i], vb[i], vd[i], vpe[i], 1'b0, vas[i]);
      v4 = 1'b0;
      wait4();
      chk("dense_p", p4, -100);
      tick();
      for (int i = 0; i < 4; i++) begin
         send4(va[i], vb[i], vd[i], vpe[i], 1'b0, vas[i]);
         chk("sparse_busy_a", busy4, 1);
         v4 = 1'b0;
         tick();
         chk("sparse_busy_b", busy4, 1);
      end
      for (int n = 0; n < 20 && !ov4; n++) begin
         chk("sparse_busy_tail", busy4, 1);
         tick();
      end
      chk("sparse_valid", ov4, 1);
      chk("sparse_p", p4, -100);
      chk("sparse_busy_done", busy4, 0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dsp_mac_unit.md
DSP_MAC_UNIT -- requirements
Module: dsp_mac_unit

Interface
REQ-001 SHALL have parameter A_WIDTH, default 18: signed width of A.
REQ-002 SHALL have parameter B_WIDTH, default 18: signed width of B and D.
REQ-003 SHALL have parameter P_WIDTH, default 48: signed accumulator/result width; legal only if P_WIDTH >= A_WIDTH+B_WIDTH+1.
REQ-004 SHALL have parameter ACC_LEN, default 16: products per frame, legal range 1..65535.
REQ-005 SHALL have parameter SATURATE, default 1: 1 = clamp on overflow, 0 = two's-complement wrap.
REQ-006 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-007 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port IN_VALID  input  1  sample valid.
REQ-009 SHALL have port IN_READY  output  1  sample accepted when IN_VALID && IN_READY.
REQ-010 SHALL have port A  input  A_WIDTH  signed multiplier operand.
REQ-011 SHALL have port B  input  B_WIDTH  signed pre-adder operand.
REQ-012 SHALL have port D  input  B_WIDTH  signed pre-adder operand.
REQ-013 SHALL have port PREADD_EN  input  1  per sample; 1 = use pre-adder result, 0 = use B.
REQ-014 SHALL have port PRE_SUB  input  1  per sample; 0 = D+B, 1 = D-B.
REQ-015 SHALL have port ACC_SUB  input  1  per sample; 0 = add product, 1 = subtract product.
REQ-016 SHALL have port OUT_VALID  output  1  frame result valid.
REQ-017 SHALL have port OUT_READY  input  1  result consumed when OUT_VALID && OUT_READY.
REQ-018 SHALL have port P  output  P_WIDTH  signed frame result.
REQ-019 SHALL have port OVERFLOW  output  1  overflow occurred in the frame held on P.
REQ-020 SHALL have port BUSY  output  1  frame in progress (sample count nonzero or any pipeline stage valid).

Function
REQ-021 SHALL implement 3 register stages: S1 registers A, B, D and control bits; S2 registers the pre-add result (B_WIDTH+1 bits, sign-extended) and the signed product (A_WIDTH+B_WIDTH+1 bits); S3 accumulates into a P_WIDTH register.
REQ-022 SHALL advance every stage, and the sample counter, only when EN = !(OUT_VALID && !OUT_READY); IN_READY SHALL equal EN.
REQ-023 SHALL carry a valid bit and a last bit per stage; bubbles (no accepted sample) SHALL NOT change the accumulator.
REQ-024 SHALL count accepted samples 0..ACC_LEN-1; the sample accepted at count ACC_LEN-1 is marked last and the count wraps to 0.
REQ-025 SHALL sign-extend the product to P_WIDTH and add or subtract it per ACC_SUB; the first sample of a frame SHALL load (0 +/- product), not add to the stale sum.
REQ-026 SHALL, with SATURATE=1, clamp an overflowing sum to +(2^(P_WIDTH-1)-1) or -2^(P_WIDTH-1) and continue from the clamped value; with SATURATE=0 SHALL wrap.
REQ-027 SHALL set the frame overflow flag on any overflowing step in the frame, independent of SATURATE, and clear it at frame start.
REQ-028 SHALL, when the last sample leaves S3, load the final sum into P and its flag into OVERFLOW and set OUT_VALID; latency: OUT_VALID high after the 3rd enabled rising edge following the edge that accepted the last sample.
REQ-029 SHALL hold P, OVERFLOW and OUT_VALID stable while OUT_VALID && !OUT_READY; OUT_VALID SHALL clear on handshake unless a new result loads on the same edge.
REQ-030 SHALL accept a new frame's first sample on the edge after the previous frame's last sample, with no dead cycle.

Reset
REQ-031 SHALL, on RST high, immediately clear all stage registers, valid/last bits, the counter and the accumulator, and drive P=0, OVERFLOW=0, OUT_VALID=0, BUSY=0; IN_READY=1 after release.
REQ-032 SHALL discard a partially accumulated frame when RST asserts mid-frame; the next accepted sample starts a fresh frame at count 0.

Verification
REQ-033 SHALL cover: ACC_LEN=4, A=2, B=3, PREADD_EN=0, 4 back-to-back samples -> P=24, OUT_VALID 3 edges after the 4th accept, OVERFLOW=0.
REQ-034 SHALL cover: ACC_LEN=2, A=5, D=10, B=4, PREADD_EN=1, PRE_SUB=1, then ACC_SUB=1 on 2nd sample with B=-4 -> (30) - (70) = P=-40.
REQ-035 SHALL cover: A_WIDTH=B_WIDTH=8, P_WIDTH=20, ACC_LEN=64, A=B=-128 -> SATURATE=1: P=524287, OVERFLOW=1; SATURATE=0: P=0, OVERFLOW=1.
REQ-036 SHALL cover: OUT_READY=0 for 10 cycles with IN_VALID=1 -> IN_READY=0, P stable, no sample lost; after OUT_READY=1 the next frame's result is correct.
REQ-037 SHALL cover: RST pulse after 2 of 4 samples -> outputs zero at once; 4 new samples A=1, B=1 -> P=4.
REQ-038 SHALL cover: IN_VALID toggling every other cycle -> same P as back-to-back input, BUSY high from first accept until OUT_VALID.
